// File: rtl/pulse_stretch.sv
// Stretches single-cycle requests into HIGH_CYCLES-wide pulses separated by at least LOW_CYCLES low.
// Optional request queue enabled by defining PULSE_STRETCH_QUEUE_EN; otherwise overlapping requests are dropped.
module pulse_stretch #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              i,
  input  logic              clr,
  output logic              o,
  output logic              busy,
  output logic              dropped,
  output logic [PEND_W-1:0] pend
);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  localparam logic [15:0] HIGH_LOAD = 16'(HIGH_CYCLES - 1);
  localparam logic [15:0] LOW_LOAD  = 16'(LOW_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        start_ok;
  logic        have_pend;
  logic        loss;

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q, pend_nxt;

  assign pend      = pend_q;
  assign have_pend = (pend_q != '0);
`else
  assign pend      = '0;
  assign have_pend = 1'b0;
`endif

  // A new pulse may begin from IDLE or on the last cycle of the gap.
  assign start_ok = (state == IDLE) || ((state == GAP) && (cnt == 16'd0));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss      = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
    pend_nxt  = pend_q;
`endif

    case (state)
      HIGH: begin
        if (cnt == 16'd0) begin
          state_nxt = GAP;
          cnt_nxt   = LOW_LOAD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      GAP: begin
        if (cnt != 16'd0) cnt_nxt = cnt - 16'd1;
      end
      default: ;
    endcase

    if (start_ok) begin
      if (i || have_pend) begin
        state_nxt = HIGH;
        cnt_nxt   = HIGH_LOAD;
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = 16'd0;
      end
`ifdef PULSE_STRETCH_QUEUE_EN
      // Queued request goes first; a simultaneous i takes its place in the queue.
      if (have_pend && !i) pend_nxt = pend_q - PEND_ONE;
`endif
    end else if (i) begin
`ifdef PULSE_STRETCH_QUEUE_EN
      if (pend_q == PEND_MAX) loss = 1'b1;
      else                    pend_nxt = pend_q + PEND_ONE;
`else
      loss = 1'b1;
`endif
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      o       <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      o       <= (state_nxt == HIGH);
      busy    <= (state_nxt != IDLE);
      dropped <= loss | (dropped & ~clr);
    end
  end

`ifdef PULSE_STRETCH_QUEUE_EN
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_nxt;
  end
`endif

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch; expectations come from a phase-based reference model.
// Handles both builds (PULSE_STRETCH_QUEUE_EN defined or not).
module tb_pulse_stretch;

  localparam int H    = 4;
  localparam int L    = 4;
  localparam int PW   = 2;
  localparam int PMAX = (1 << PW) - 1;

  logic          c = 1'b0;
  logic          rst_n;
  logic          i;
  logic          clr;
  logic          o;
  logic          busy;
  logic          dropped;
  logic [PW-1:0] pend;

  pulse_stretch #(
    .HIGH_CYCLES(H),
    .LOW_CYCLES (L),
    .PEND_W     (PW)
  ) dut (
    .c      (c),
    .rst_n  (rst_n),
    .i      (i),
    .clr    (clr),
    .o      (o),
    .busy   (busy),
    .dropped(dropped),
    .pend   (pend)
  );

  always #5 c = ~c;

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;
  logic prev_o = 1'b0;

  // {o, busy, dropped, pend}
  logic [PW+2:0] exp_q[$];

  // Model: m_ph = -1 when idle, otherwise cycles since the pulse started (0..H+L-1).
  int m_ph   = -1;
  int m_pend = 0;
  bit m_drop = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW+2:0] model_step(input bit iv, input bit cv);
    bit loss = 1'b0;
    if (m_ph < 0 || m_ph == H + L - 1) begin
      if (m_pend > 0) begin
        m_ph = 0;
        if (!iv) m_pend = m_pend - 1;
      end else if (iv) begin
        m_ph = 0;
      end else begin
        m_ph = -1;
      end
    end else begin
      m_ph = m_ph + 1;
      if (iv) begin
`ifdef PULSE_STRETCH_QUEUE_EN
        if (m_pend == PMAX) loss = 1'b1;
        else                m_pend = m_pend + 1;
`else
        loss = 1'b1;
`endif
      end
    end
    if (loss)    m_drop = 1'b1;
    else if (cv) m_drop = 1'b0;
    return {(m_ph >= 0 && m_ph < H), (m_ph >= 0), m_drop, PW'(m_pend)};
  endfunction

  task automatic sample_check();
    logic [PW+2:0] e;
    @(posedge c);
    #1;
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("o",       32'(o),       32'(e[PW+2]));
      check_val("busy",    32'(busy),    32'(e[PW+1]));
      check_val("dropped", 32'(dropped), 32'(e[PW]));
      check_val("pend",    32'(pend),    32'(e[PW-1:0]));
    end
    if (o === 1'b1 && prev_o === 1'b0) pulses++;
    prev_o = o;
  endtask

  task automatic cycle(input bit iv, input bit cv);
    @(negedge c);
    i   = iv;
    clr = cv;
    exp_q.push_back(model_step(iv, cv));
    sample_check();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_ph   = -1;
    m_pend = 0;
    m_drop = 1'b0;
    prev_o = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i     = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge c);
    #1;
    check_val("rst_o",       32'(o),       32'd0);
    check_val("rst_busy",    32'(busy),    32'd0);
    check_val("rst_dropped", 32'(dropped), 32'd0);
    check_val("rst_pend",    32'(pend),    32'd0);
    @(negedge c);
    rst_n = 1'b1;
    model_reset();
    idle(5);

    // Single request.
    cycle(1'b1, 1'b0);
    idle(12);

    // Three back-to-back requests.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
    idle(28);

    // Six back-to-back requests: queue saturates or requests drop.
    pulses = 0;
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0);
    idle(40);
`ifdef PULSE_STRETCH_QUEUE_EN
    check_val("burst_pulses", 32'(pulses), 32'd4);
`else
    check_val("burst_pulses", 32'(pulses), 32'd1);
`endif
    cycle(1'b0, 1'b1);
    idle(2);

    // Request during HIGH, then clear.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    idle(6);
    cycle(1'b0, 1'b1);
    idle(10);

    // Request on the final gap cycle restarts without an idle cycle.
    cycle(1'b1, 1'b0);
    idle(7);
    cycle(1'b1, 1'b0);
    idle(12);

    // Request in the same cycle as clr.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    idle(30);
    cycle(1'b0, 1'b1);

    // Asynchronous reset mid-pulse with requests queued.
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    @(negedge c);
    i   = 1'b0;
    clr = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_o",       32'(o),       32'd0);
    check_val("arst_busy",    32'(busy),    32'd0);
    check_val("arst_pend",    32'(pend),    32'd0);
    check_val("arst_dropped", 32'(dropped), 32'd0);
    repeat (2) @(posedge c);
    @(negedge c);
    model_reset();
    rst_n = 1'b1;
    i     = 1'b1;
    exp_q.push_back(model_step(1'b1, 1'b0));
    sample_check();
    idle(12);

    // Random traffic.
    for (int k = 0; k < 300; k++)
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter HIGH_CYCLES, default 4, output high time in clocks; legal range 1..65535.
REQ-002 Parameter LOW_CYCLES, default 4, minimum output low time after each pulse in clocks; legal range 1..65535.
REQ-003 Parameter PEND_W, default 4, width of the pending-pulse counter; legal range 1..8.
REQ-004 c  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i  input  1  single-cycle request pulse, synchronous to c; each high cycle is one request.
REQ-007 clr  input  1  synchronous clear of dropped.
REQ-008 o  output  1  stretched pulse, registered, glitch-free.
REQ-009 busy  output  1  registered; high whenever the state is not IDLE.
REQ-010 dropped  output  1  sticky flag; a request was lost.
REQ-011 pend  output  PEND_W  count of queued requests not yet emitted.

Function
REQ-012 The state machine SHALL have three states: IDLE, HIGH, GAP; one down-counter, 16 bits.
REQ-013 IDLE: i=1 or pend>0 -> HIGH, counter loaded with HIGH_CYCLES-1; o=1 from the next cycle.
REQ-014 Latency: i high in cycle N -> o high in cycles N+1 .. N+HIGH_CYCLES.
REQ-015 HIGH: counter decrements each cycle; at counter=0 -> GAP, counter loaded with LOW_CYCLES-1, o=0 next cycle.
REQ-016 GAP: counter decrements; at counter=0 -> HIGH if i=1 or pend>0, else IDLE; no IDLE cycle is inserted.
REQ-017 o SHALL be high for exactly HIGH_CYCLES consecutive cycles per emitted pulse and low for at least LOW_CYCLES cycles between pulses.
REQ-018 A start from pend>0 with i=0 SHALL decrement pend by 1 in the same cycle as the transition into HIGH.
REQ-019 A start caused by i=1 SHALL be taken directly; pend unchanged if pend=0.
REQ-020 Start cycle with i=1 and pend>0: pend emits first, i is queued; pend net unchanged.
REQ-021 i=1 in any HIGH cycle or non-final GAP cycle is handled per Configuration.
REQ-022 dropped SHALL set on every lost request; clr=1 clears it; a loss in the same cycle as clr leaves dropped=1 (set wins).
REQ-023 busy SHALL be 0 in IDLE and 1 in HIGH and GAP.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, counter 0, o=0, busy=0, dropped=0, pend=0, independent of c.
REQ-025 Reset mid-pulse SHALL truncate o without completing HIGH or GAP; queued requests are discarded.
REQ-026 The first rising edge of c after rst_n deassertion SHALL accept i normally.

Configuration
REQ-027 Macro PULSE_STRETCH_QUEUE_EN defined: requests per REQ-021 increment pend; at pend=2^PEND_W-1 the request is lost and dropped sets; pend saturates, never wraps.
REQ-028 Macro PULSE_STRETCH_QUEUE_EN undefined: requests per REQ-021 are lost and set dropped; pend is tied to 0; no counter logic is synthesized.

Verification (HIGH_CYCLES=4, LOW_CYCLES=4, PEND_W=2 unless noted)
REQ-029 Single i at cycle 10 -> o=1 cycles 11-14; busy=1 cycles 11-18; IDLE at 19; dropped=0.
REQ-030 QUEUE_EN, i at cycles 10,11,12 -> o=1 at 11-14, 19-22, 27-30; pend peaks at 2, returns to 0 at 27.
REQ-031 QUEUE_EN, i at 10 then 5 more during 11-15 -> pend saturates at 3, dropped=1, exactly 4 output pulses.
REQ-032 No QUEUE_EN, i at 10 and 12 -> one output pulse 11-14, dropped=1 from 13; clr at 20 -> dropped=0 at 21.
REQ-033 i at 10 and at final GAP cycle 18 -> o=1 at 11-14 and 19-22, busy stays 1 through 26.
REQ-034 QUEUE_EN, pend=2, rst_n low at cycle 12 for 2 cycles -> o=0 asynchronously, pend=0, i at 16 -> o=1 at 17-20.
